// File: rtl/uart_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_depacketizer
//  Brief    : 8N1 UART receiver feeding a SYNC/LEN/payload/CHK packet parser,
//             emitting payload bytes with packet start/end/error strobes.
//  Revision : 1.0  initial release
// ============================================================================
module uart_depacketizer #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       pkt_err,
    output logic       rx_busy
);

    localparam int                c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]        c_max_len  = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        P_HUNT    = 2'd0,
        P_LEN     = 2'd1,
        P_PAYLOAD = 2'd2,
        P_CHK     = 2'd3
    } pkt_state_t;

    logic               r_sync1;
    logic               r_sync2;
    bit_state_t         r_bit_state;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    pkt_state_t         r_pkt_state;
    logic [7:0]         r_count;
    logic [7:0]         r_chk;
    logic               r_emitted;

    logic               w_line;
    logic               w_byte_stb;
    logic               w_byte_ok;

    assign w_line     = r_sync2;
    // Stop-bit sample cycle: the packet FSM consumes the byte on this edge.
    assign w_byte_stb = (r_bit_state == B_STOP) && (r_bit_cnt == c_cnt_last);
    assign w_byte_ok  = w_line;

    assign rx_busy = (r_bit_state != B_IDLE) || (r_pkt_state != P_HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_state <= B_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
        end else begin
            case (r_bit_state)
                B_IDLE: begin
                    if (!w_line) begin
                        r_bit_state <= B_START;
                        r_bit_cnt   <= '0;
                    end
                end
                B_START: begin
                    if (r_bit_cnt == c_cnt_half) begin
                        r_bit_cnt   <= '0;
                        r_bit_idx   <= 3'd0;
                        r_bit_state <= w_line ? B_IDLE : B_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (r_bit_cnt == c_cnt_last) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {w_line, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_state <= B_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (r_bit_cnt == c_cnt_last) begin
                        r_bit_cnt   <= '0;
                        r_bit_state <= B_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_bit_state <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_state    <= P_HUNT;
            r_count        <= 8'h00;
            r_chk          <= 8'h00;
            r_emitted      <= 1'b0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            pkt_start      <= 1'b0;
            pkt_end        <= 1'b0;
            pkt_err        <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            pkt_start      <= 1'b0;
            pkt_end        <= 1'b0;
            pkt_err        <= 1'b0;
            if (w_byte_stb) begin
                case (r_pkt_state)
                    P_HUNT: begin
                        if (w_byte_ok && (r_shift == SYNC_BYTE)) begin
                            r_pkt_state <= P_LEN;
                        end
                    end
                    P_LEN: begin
                        if (!w_byte_ok || (r_shift == 8'h00) || (r_shift > c_max_len)) begin
                            pkt_err     <= 1'b1;
                            r_pkt_state <= P_HUNT;
                        end else begin
                            r_count     <= r_shift;
                            r_chk       <= r_shift;
                            r_emitted   <= 1'b0;
                            r_pkt_state <= P_PAYLOAD;
                        end
                    end
                    P_PAYLOAD: begin
                        if (!w_byte_ok) begin
                            pkt_err     <= 1'b1;
                            pkt_end     <= r_emitted;
                            r_pkt_state <= P_HUNT;
                        end else begin
                            data_out       <= r_shift;
                            data_out_valid <= 1'b1;
                            pkt_start      <= !r_emitted;
                            r_emitted      <= 1'b1;
                            r_chk          <= r_chk ^ r_shift;
                            r_count        <= r_count - 8'd1;
                            if (r_count == 8'd1) begin
                                r_pkt_state <= P_CHK;
                            end
                        end
                    end
                    P_CHK: begin
                        // At least one payload byte has always been emitted here.
                        pkt_end     <= 1'b1;
                        pkt_err     <= !w_byte_ok || (r_shift != r_chk);
                        r_pkt_state <= P_HUNT;
                    end
                    default: r_pkt_state <= P_HUNT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
